// File: rtl/sw_pkg.sv
// rtl/sw_pkg.sv - shared switch types, flag levels and width helpers
package sw_pkg;

  localparam int PKTW = 8;

  localparam logic ASSERT = 1'b1;
  localparam logic NEGATE = 1'b0;

  localparam int DEF_DEPTH = 4;
  localparam int DEF_NVC   = 2;

  function automatic int calc_vcw(input int nvc);
    return (nvc > 1) ? $clog2(nvc) : 1;
  endfunction

  function automatic int calc_cw(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef logic [PKTW:0]                     pkt_t;
  typedef logic [calc_vcw(DEF_NVC)-1:0]      vc_t;
  typedef logic [calc_cw(DEF_DEPTH)-1:0]     cnt_t;

endpackage

// File: rtl/vc_fifo_ch.sv
// rtl/vc_fifo_ch.sv - single-channel FIFO with occupancy and credit flags
module vc_fifo_ch
  import sw_pkg::*;
#(
  parameter int W        = PKTW + 1,
  parameter int DEPTH    = 4,
  parameter int AFULL_TH = DEPTH - 1,
  parameter int CW       = calc_cw(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          empty,
  output logic          full,
  output logic          afull,
  output logic [CW-1:0] cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Storage is deliberately left unreset; push is already qualified by the top.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[head_q[AW-1:0]] <= din;
    end
  end

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (push) begin
      head_d = head_q + PW'(1);
    end
    if (pop) begin
      tail_d = tail_q + PW'(1);
    end
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout  = mem_q[tail_q[AW-1:0]];
  assign cnt   = cnt_q;
  assign empty = (cnt_q == '0)             ? ASSERT : NEGATE;
  assign full  = (cnt_q == CW'(DEPTH))     ? ASSERT : NEGATE;
  assign afull = (cnt_q >= CW'(AFULL_TH))  ? ASSERT : NEGATE;

endmodule

// File: rtl/vc_fifo.sv
// rtl/vc_fifo.sv - multi-channel packet buffer with sticky overflow/underflow
module vc_fifo
  import sw_pkg::*;
#(
  parameter int W        = PKTW + 1,
  parameter int DEPTH    = 4,
  parameter int NVC      = 2,
  parameter int AFULL_TH = DEPTH - 1,
  localparam int VCW     = calc_vcw(NVC),
  localparam int CW      = calc_cw(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W-1:0]      in,
  input  logic              we,
  input  logic [VCW-1:0]    wvc,
  output logic [W-1:0]      out,
  input  logic              re,
  input  logic [VCW-1:0]    rvc,
  output logic [NVC-1:0]    empty,
  output logic [NVC-1:0]    full,
  output logic [NVC-1:0]    afull,
  output logic [NVC*CW-1:0] cnt,
  output logic              ovf,
  output logic              udf
);

  logic [NVC-1:0] push_req, pop_req;
  logic [NVC-1:0] push_en, pop_en;
  logic [W-1:0]   ch_dout [NVC];
  logic           ovf_q, ovf_d;
  logic           udf_q, udf_d;

  // Out-of-range channel numbers decode to no request at all, so they raise no flag.
  always_comb begin
    push_req = '0;
    pop_req  = '0;
    for (int v = 0; v < NVC; v++) begin
      push_req[v] = we && (int'(wvc) == v);
      pop_req[v]  = re && (int'(rvc) == v);
    end
    pop_en  = pop_req & ~empty & {NVC{~rst}};
    // A full channel still accepts a write when it is popped in the same cycle.
    push_en = push_req & (~full | pop_en) & {NVC{~rst}};
    ovf_d   = ovf_q | (|(push_req & full & ~pop_en));
    udf_d   = udf_q | (|(pop_req & empty));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= NEGATE;
      udf_q <= NEGATE;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign ovf = ovf_q;
  assign udf = udf_q;

  for (genvar g = 0; g < NVC; g++) begin : g_ch
    vc_fifo_ch #(
      .W        (W),
      .DEPTH    (DEPTH),
      .AFULL_TH (AFULL_TH),
      .CW       (CW)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .push  (push_en[g]),
      .pop   (pop_en[g]),
      .din   (in),
      .dout  (ch_dout[g]),
      .empty (empty[g]),
      .full  (full[g]),
      .afull (afull[g]),
      .cnt   (cnt[g*CW +: CW])
    );
  end

  always_comb begin
    out = '0;
    for (int v = 0; v < NVC; v++) begin
      if ((int'(rvc) == v) && !empty[v]) begin
        out = ch_dout[v];
      end
    end
  end

endmodule

// File: tb/tb_vc_fifo.sv
// tb/tb_vc_fifo.sv - directed scoreboard bench for vc_fifo (DEPTH=4, NVC=2, AFULL_TH=3)
module tb_vc_fifo;
  import sw_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic       clk = 1'b0;
  logic       rst;
  pkt_t       din;
  logic       we;
  logic [0:0] wvc;
  pkt_t       dout;
  logic       re;
  logic [0:0] rvc;
  logic [1:0] empty, full, afull;
  logic [5:0] cnt;
  logic       ovf, udf;

  int   vectors     = 0;
  int   miscompares = 0;
  pkt_t sb0 [$];
  pkt_t sb1 [$];
  logic m_ovf, m_udf;

  always #5 clk = ~clk;

  vc_fifo #(.DEPTH(4), .NVC(2), .AFULL_TH(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .in    (din),
    .we    (we),
    .wvc   (wvc),
    .out   (dout),
    .re    (re),
    .rvc   (rvc),
    .empty (empty),
    .full  (full),
    .afull (afull),
    .cnt   (cnt),
    .ovf   (ovf),
    .udf   (udf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sz(input int v);
    return (v == 0) ? sb0.size() : sb1.size();
  endfunction

  function automatic pkt_t front(input int v);
    if (sz(v) == 0) return '0;
    return (v == 0) ? sb0[0] : sb1[0];
  endfunction

  task automatic check_state(input string tag);
    for (int v = 0; v < 2; v++) begin
      chk($sformatf("%s_cnt%0d", tag, v),   32'(cnt[v*CW +: CW]), 32'(sz(v)));
      chk($sformatf("%s_empty%0d", tag, v), 32'(empty[v]),        32'(sz(v) == 0));
      chk($sformatf("%s_full%0d", tag, v),  32'(full[v]),         32'(sz(v) == DEPTH));
      chk($sformatf("%s_afull%0d", tag, v), 32'(afull[v]),        32'(sz(v) >= 3));
    end
    chk({tag, "_ovf"}, 32'(ovf), 32'(m_ovf));
    chk({tag, "_udf"}, 32'(udf), 32'(m_udf));
  endtask

  // One clocked operation: out is checked before the edge, state after it.
  task automatic op(input string tag, input logic w, input logic wc, input pkt_t d,
                    input logic r, input logic rc);
    bit pop_ok, push_ok;
    we = w; wvc = wc; din = d; re = r; rvc = rc;
    #1;
    chk({tag, "_out_pre"}, 32'(dout), 32'(front(int'(rc))));
    pop_ok  = r && (sz(int'(rc)) > 0);
    push_ok = w && ((sz(int'(wc)) < DEPTH) || (pop_ok && (rc == wc)));
    if (w && !push_ok) m_ovf = 1'b1;
    if (r && !pop_ok)  m_udf = 1'b1;
    if (pop_ok) begin
      if (rc == 1'b0) void'(sb0.pop_front()); else void'(sb1.pop_front());
    end
    if (push_ok) begin
      if (wc == 1'b0) sb0.push_back(d); else sb1.push_back(d);
    end
    @(posedge clk); #1;
    we = 1'b0; re = 1'b0;
    check_state(tag);
    chk({tag, "_out_post"}, 32'(dout), 32'(front(int'(rc))));
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1; we = 1'b1; wvc = 1'b0; din = 9'h1FF; re = 1'b1; rvc = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; we = 1'b0; re = 1'b0;
    sb0.delete(); sb1.delete();
    m_ovf = 1'b0; m_udf = 1'b0;
    check_state(tag);
    chk({tag, "_empty_all"}, 32'(empty), 32'h3);
    for (int v = 0; v < 2; v++) begin
      rvc = 1'(v); #1;
      chk($sformatf("%s_out%0d", tag, v), 32'(dout), 32'h0);
    end
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; re = 1'b0; wvc = 1'b0; rvc = 1'b0; din = '0;
    m_ovf = 1'b0; m_udf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset("rst0");

    op("wrA", 1, 0, 9'h0A1, 0, 0);
    op("wrB", 1, 0, 9'h0B2, 0, 0);
    op("wrC", 1, 0, 9'h0C3, 0, 0);
    chk("afull_at3", 32'(afull[0]), 32'h1);
    op("wrD", 1, 0, 9'h0D4, 0, 0);
    chk("full_at4", 32'(full[0]), 32'h1);
    op("wrE_drop", 1, 0, 9'h0E5, 0, 0);
    chk("ovf_set", 32'(ovf), 32'h1);
    for (int i = 0; i < 4; i++) op($sformatf("rd%0d", i), 0, 0, '0, 1, 0);
    chk("empty_after_drain", 32'(empty[0]), 32'h1);

    do_reset("rst1");
    op("fA", 1, 0, 9'h0A1, 0, 0);
    op("fB", 1, 0, 9'h0B2, 0, 0);
    op("fC", 1, 0, 9'h0C3, 0, 0);
    op("fD", 1, 0, 9'h0D4, 0, 0);
    op("full_rw", 1, 0, 9'h0E5, 1, 0);
    chk("full_rw_out", 32'(dout), 32'h0B2);
    chk("full_rw_ovf", 32'(ovf), 32'h0);
    for (int i = 0; i < 4; i++) op($sformatf("frd%0d", i), 0, 0, '0, 1, 0);

    op("wrP", 1, 0, 9'h050, 0, 0);
    op("wrQ", 1, 0, 9'h051, 0, 0);
    op("ilv", 1, 1, 9'h1AA, 1, 0);
    op("ilv_x", 0, 0, '0, 0, 1);
    chk("ilv_x_out", 32'(dout), 32'h1AA);

    op("wrY", 1, 1, 9'h1BB, 0, 1);
    for (int i = 0; i < 10; i++) begin
      op($sformatf("wrap%0d", i), 1, 1, pkt_t'($urandom_range(0, 511)), 1, 1);
    end
    chk("wrap_cnt", 32'(cnt[CW +: CW]), 32'h2);
    op("drain1a", 0, 0, '0, 1, 1);
    op("drain1b", 0, 0, '0, 1, 1);

    op("udf_rw", 1, 1, 9'h0CC, 1, 1);
    chk("udf_set", 32'(udf), 32'h1);
    chk("udf_cnt1", 32'(cnt[CW +: CW]), 32'h1);

    op("pre_rst", 1, 0, 9'h077, 0, 0);
    do_reset("rst_mid");
    chk("rst_mid_ovf", 32'(ovf), 32'h0);
    chk("rst_mid_udf", 32'(udf), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
